// File: rtl/switch_load_conditioner.sv
// Switch/button front end: synchronizers, per-line debounce and the one-cycle load strobe.
// Build option: define AUTO_LOAD_EN to also strobe 'enabling' on any debounced switch change.
module switch_load_conditioner #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             btn_load_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic             btn_clean,
  output logic             enabling
);

  localparam int NL = WIDTH + 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NL-1:0]                   raw_vec;
  logic [SYNC_STAGES-1:0][NL-1:0]  sync_q, sync_d;
  logic [NL-1:0]                   sync_x;
  logic [NL-1:0]                   clean_q, clean_d;
  logic [NL-1:0][CW-1:0]           cnt_q, cnt_d;
  logic                            btn_q, btn_d;
  logic                            enabling_q, enabling_d;
  logic                            load_edge;

  // Button rides as the top line so all lines share one synchronizer/debounce path.
  assign raw_vec = {btn_load_raw, sw_raw};
  assign sync_x  = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_vec};
  end

  always_comb begin
    clean_d = clean_q;
    cnt_d   = '0;
    for (int i = 0; i < NL; i++) begin
      if (sync_x[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = sync_x[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign btn_d     = clean_q[WIDTH];
  assign load_edge = clean_q[WIDTH] & ~btn_q;

`ifdef AUTO_LOAD_EN
  logic [WIDTH-1:0] sw_q, sw_d;

  assign sw_d = clean_q[WIDTH-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_q <= '0;
    end else begin
      sw_q <= sw_d;
    end
  end

  // A coincident button edge and switch change merge into one pulse.
  always_comb begin
    enabling_d = load_edge | (clean_q[WIDTH-1:0] != sw_q);
  end
`else
  always_comb begin
    enabling_d = load_edge;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      clean_q    <= '0;
      cnt_q      <= '0;
      btn_q      <= 1'b0;
      enabling_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      clean_q    <= clean_d;
      cnt_q      <= cnt_d;
      btn_q      <= btn_d;
      enabling_q <= enabling_d;
    end
  end

  assign sw_clean  = clean_q[WIDTH-1:0];
  assign btn_clean = clean_q[WIDTH];
  assign enabling  = enabling_q;

endmodule

// File: tb/tb_switch_load_conditioner.sv
// Directed bench for switch_load_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 80 ns clock.
module tb_switch_load_conditioner;

  localparam int W = 4;
`ifdef AUTO_LOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic         btn_load_raw;
  logic [W-1:0] sw_clean;
  logic         btn_clean;
  logic         enabling;

  int n_cmp = 0;
  int n_err = 0;

  switch_load_conditioner #(
    .WIDTH(W),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .sw_raw(sw_raw),
    .btn_load_raw(btn_load_raw),
    .sw_clean(sw_clean),
    .btn_clean(btn_clean),
    .enabling(enabling)
  );

  always #40 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  int pulses;
  int en_run;
  bit btn_seen;

  initial begin
    reset_n      = 1'b0;
    sw_raw       = 4'b1111;
    btn_load_raw = 1'b0;

    // 1: reset holds everything at 0 across edges, then 6-edge qualification
    tick(3);
    check_val("rst_sw", {28'd0, sw_clean}, 32'h0);
    check_val("rst_btn", {31'd0, btn_clean}, 32'h0);
    check_val("rst_en", {31'd0, enabling}, 32'h0);
    reset_n = 1'b1;
    tick(5);
    check_val("t1_edge5", {28'd0, sw_clean}, 32'h0);
    tick(1);
    check_val("t1_edge6", {28'd0, sw_clean}, 32'hf);
    check_val("t1_en6", {31'd0, enabling}, 32'h0);
    tick(1);
    check_val("t1_en7", {31'd0, enabling}, {31'd0, AUTO});
    tick(2);

    // 2: sw_raw[1] chatters with a 4-cycle period, then held low
    btn_seen = 1'b0;
    for (int p = 0; p < 5; p++) begin
      sw_raw[1] = 1'b0;
      tick(1);
      if (sw_clean[1] !== 1'b1) btn_seen = 1'b1;
      tick(1);
      if (sw_clean[1] !== 1'b1) btn_seen = 1'b1;
      sw_raw[1] = 1'b1;
      tick(1);
      if (sw_clean[1] !== 1'b1) btn_seen = 1'b1;
      tick(1);
      if (sw_clean[1] !== 1'b1) btn_seen = 1'b1;
    end
    check_val("t2_chatter", {31'd0, btn_seen}, 32'h0);
    sw_raw[1] = 1'b0;
    tick(5);
    check_val("t2_hold5", {28'd0, sw_clean}, 32'hf);
    tick(1);
    check_val("t2_hold6", {28'd0, sw_clean}, 32'hd);

    // 3: settle 1010, hold button 10 cycles -> single 1-cycle strobe
    sw_raw = 4'b1010;
    tick(6);
    check_val("t3_sw", {28'd0, sw_clean}, 32'ha);
    tick(3);
    btn_load_raw = 1'b1;
    tick(6);
    check_val("t3_btn6", {31'd0, btn_clean}, 32'h1);
    check_val("t3_en6", {31'd0, enabling}, 32'h0);
    tick(1);
    check_val("t3_en7", {31'd0, enabling}, 32'h1);
    check_val("t3_sw_at_en", {28'd0, sw_clean}, 32'ha);
    pulses = 1;
    en_run = 1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      if (enabling) begin
        en_run++;
      end
    end
    check_val("t3_width", en_run, 32'd1);
    btn_load_raw = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (enabling) pulses++;
    end
    check_val("t3_release_pulses", pulses, 32'd0);
    check_val("t3_btn_off", {31'd0, btn_clean}, 32'h0);

    // 4: 3-cycle button glitch is rejected
    btn_load_raw = 1'b1;
    tick(3);
    btn_load_raw = 1'b0;
    btn_seen = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (btn_clean) btn_seen = 1'b1;
      if (enabling) pulses++;
    end
    check_val("t4_btn", {31'd0, btn_seen}, 32'h0);
    check_val("t4_en", pulses, 32'd0);

    // 5: async reset with counters at 2, then full requalification
    sw_raw = 4'b0101;
    tick(4);
    check_val("t5_pre", {28'd0, sw_clean}, 32'ha);
    reset_n = 1'b0;
    #5;
    check_val("t5_async_sw", {28'd0, sw_clean}, 32'h0);
    check_val("t5_async_en", {31'd0, enabling}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    check_val("t5_req5", {28'd0, sw_clean}, 32'h0);
    tick(1);
    check_val("t5_req6", {28'd0, sw_clean}, 32'h5);
    tick(3);

`ifdef AUTO_LOAD_EN
    // 6: switch-change strobe, and merged strobe with a coincident button edge
    sw_raw = 4'b1111;
    tick(9);
    sw_raw = 4'b0101;
    tick(6);
    check_val("t6_sw", {28'd0, sw_clean}, 32'h5);
    check_val("t6_en6", {31'd0, enabling}, 32'h0);
    tick(1);
    check_val("t6_en7", {31'd0, enabling}, 32'h1);
    tick(1);
    check_val("t6_en8", {31'd0, enabling}, 32'h0);
    tick(2);
    sw_raw = 4'b1111;
    btn_load_raw = 1'b1;
    tick(6);
    check_val("t6_both_btn", {31'd0, btn_clean}, 32'h1);
    tick(1);
    check_val("t6_both_en7", {31'd0, enabling}, 32'h1);
    tick(1);
    check_val("t6_both_en8", {31'd0, enabling}, 32'h0);
    btn_load_raw = 1'b0;
    tick(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
